inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, meaning instruction address width.
REQ-003 The module SHALL have parameter DEPTH_LOG, default 3, meaning the queue holds 2^DEPTH_LOG entries (8).
REQ-004 The module SHALL have parameter SLACK, default 2, meaning free entries reserved behind the stall threshold.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port i_valid, input, 1 bit: a fetched instruction is presented this cycle (push request from instruction cache).
REQ-008 The module SHALL have port i_addr, input, ADDR_WIDTH bits: address of the presented instruction.
REQ-009 The module SHALL have port i_data, input, DATA_WIDTH bits: presented instruction word.
REQ-010 The module SHALL have port o_stall, output, 1 bit: back-pressure to the staller/PC/cache; fetch must not issue while high.
REQ-011 The module SHALL have port o_valid, output, 1 bit: head entry is valid for the decoder.
REQ-012 The module SHALL have port o_addr, output, ADDR_WIDTH bits: head entry address.
REQ-013 The module SHALL have port o_data, output, DATA_WIDTH bits: head entry instruction.
REQ-014 The module SHALL have port i_ready, input, 1 bit: decoder consumes the head this cycle.
REQ-015 The module SHALL have port i_flush, input, 1 bit: discard all queued and incoming instructions (branch redirect).
REQ-016 The module SHALL have port o_count, output, DEPTH_LOG+1 bits: current occupancy.
REQ-017 The module SHALL have port o_overflow, output, 1 bit: sticky error flag, a push was lost because the queue was full.

Function
REQ-018 Storage SHALL be a circular buffer of {addr, data} entries with write pointer, read pointer (DEPTH_LOG bits, wrap modulo 2^DEPTH_LOG) and a DEPTH_LOG+1-bit count.
REQ-019 Push SHALL occur when i_valid=1, i_flush=0, and (count < 2^DEPTH_LOG, or a pop occurs the same cycle); the entry is written at the write pointer and the pointer increments.
REQ-020 Pop SHALL occur when o_valid=1, i_ready=1, i_flush=0; the read pointer increments; i_ready while empty is ignored.
REQ-021 Show-ahead: o_valid SHALL equal (count != 0); o_addr/o_data SHALL be the entry at the read pointer, combinationally from storage.
REQ-022 No bypass: a word pushed at edge N SHALL first appear on o_valid/o_data after edge N; latency push-to-head on an empty queue = 1 cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when count = 2^DEPTH_LOG (full) or count = 1.
REQ-024 o_stall SHALL be combinational: 1 when count >= 2^DEPTH_LOG - SLACK (6 with defaults), else 0; it is independent of i_ready.
REQ-025 Push while full with no concurrent pop SHALL drop the word, leave storage/pointers unchanged, and set o_overflow to 1 until reset.
REQ-026 i_flush=1 SHALL at the next edge set count, read and write pointers to 0; any same-cycle push or pop is discarded; o_overflow is unaffected.
REQ-027 Storage contents SHALL not be cleared by reset or flush; only pointers/count define validity.
REQ-028 o_count SHALL equal the registered count.

Reset
REQ-029 While rst=1 at a rising edge, count, both pointers and o_overflow SHALL become 0; consequently o_valid=0, o_stall=0, o_count=0 after that edge.
REQ-030 rst SHALL take priority over i_flush, push and pop; reset mid-operation discards all entries.
REQ-031 o_addr/o_data SHALL be don't-care while o_valid=0.

Verification
REQ-032 Reset then push 0x00000013 @ addr 0x0, 0x00100093 @ 0x4 on consecutive cycles, i_ready=0 -> after 2nd edge o_count=2, o_valid=1, o_addr=0x0, o_data=0x00000013.
REQ-033 Push 6 words with i_ready=0 -> o_stall goes 1 after the 6th edge (count=6), stays 0 at count=5.
REQ-034 Fill to 8, push 9th with i_ready=0 -> word dropped, o_count=8, o_overflow=1; then push+pop same cycle -> o_count=8, head advances, new word stored at tail.
REQ-035 Push 12 words while popping every cycle after the first -> pointers wrap, decoder sees addresses 0x0..0x2C in order, none lost.
REQ-036 With 4 entries queued, assert i_flush together with i_valid and i_ready -> next cycle o_count=0, o_valid=0, pushed word absent.
REQ-037 With 5 entries and o_overflow=1, assert rst for one cycle -> o_count=0, o_valid=0, o_stall=0, o_overflow=0.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: show-ahead circular buffer of
// {addr, data} entries with a stall threshold, flush, and a sticky overflow flag.
module inst_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG  = 3,
  parameter int unsigned SLACK      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic [DEPTH_LOG:0]    o_count,
  output logic                  o_overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG;
  localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DEPTH_LOG:0] FullCnt = (DEPTH_LOG + 1)'(Depth);
  localparam logic [DEPTH_LOG:0] StallCnt = (DEPTH_LOG + 1)'(Depth - SLACK);
  localparam logic [DEPTH_LOG:0] CntOne = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PtrOne = DEPTH_LOG'(1);

  logic [EntryW-1:0]    mem_q [Depth];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 full, push, pop;

  // Push/pop qualification; a pop frees the slot a full-queue push needs.
  always_comb begin
    full = (count_q == FullCnt);
    pop  = (count_q != '0) && i_ready && !i_flush;
    push = i_valid && !i_flush && (!full || pop);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (i_valid && !i_flush && full && !pop);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (!push && pop) count_d = count_q - CntOne;
    end
  end

  // Control state with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {i_addr, i_data};
  end

  // Show-ahead outputs straight from storage and registered state.
  always_comb begin
    o_valid    = (count_q != '0);
    {o_addr, o_data} = mem_q[rd_ptr_q];
    o_stall    = (count_q >= StallCnt);
    o_count    = count_q;
    o_overflow = overflow_q;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue tracks accepted pushes and
// every cycle the DUT head, occupancy, stall and overflow are compared to it.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        i_ready;
  logic        i_flush;
  logic [3:0]  o_count;
  logic        o_overflow;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb[$];
  logic        ovf_m;

  inst_queue dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_stall   (o_stall),
    .o_valid   (o_valid),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .i_flush   (i_flush),
    .o_count   (o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare current DUT state to the model, then apply one clock of stimulus.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic fl);
    logic do_pop, do_push;
    int   n;
    i_valid = v;
    i_addr  = a;
    i_data  = d;
    i_ready = rdy;
    i_flush = fl;
    n = sb.size();
    check_eq("valid", 64'(o_valid), 64'(n != 0));
    check_eq("count", 64'(o_count), 64'(n));
    check_eq("stall", 64'(o_stall), 64'(n >= 6));
    check_eq("overflow", 64'(o_overflow), 64'(ovf_m));
    if (n != 0) check_eq("head", {o_addr, o_data}, sb[0]);
    do_pop  = (n != 0) && rdy && !fl;
    do_push = v && !fl && ((n < 8) || do_pop);
    if (v && !fl && (n == 8) && !do_pop) ovf_m = 1'b1;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({a, d});
    end
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    @(posedge clk);
    sb.delete();
    ovf_m = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    ovf_m   = 1'b0;
    #1;
    do_reset();

    // Two pushes, no consumption: head is the first word.
    step(1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b1, 32'h4, 32'h0010_0093, 1'b0, 1'b0);
    // Fill past the stall threshold up to full, then one dropped push.
    for (int i = 2; i < 9; i++) step(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
    // Push and pop together while full.
    step(1'b1, 32'h24, 32'h1000_0009, 1'b1, 1'b0);
    // Drain everything, plus a ready on empty which must be ignored.
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with four queued and a concurrent push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Streaming with pointer wrap: pop every cycle after the first.
    for (int i = 0; i < 12; i++) step(1'b1, 32'(i * 4), 32'h2000_0000 + 32'(i), i > 0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Five queued with overflow still set, then reset clears everything.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h400, 32'h5000_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
